// File: rtl/mfcc_frame_scheduler_if.sv
// Sample-in, sample-RAM write and windowing-stage read handshake bundle.
// master = frame scheduler, slave = audio source / RAM / windowing stage.
interface mfcc_frame_scheduler_if #(parameter int ADDR_W = 9);
  logic               sample_valid_i;
  logic signed [15:0] sample_i;
  logic               sample_ready_o;
  logic               wr_en_o;
  logic [ADDR_W-1:0]  wr_addr_o;
  logic [15:0]        wr_data_o;
  logic               start_o;
  logic               valid_to_read_o;
  logic               rd_en_i;
  logic [ADDR_W-1:0]  rd_addr_o;
  logic               done_i;

  modport master (
    input  sample_valid_i, sample_i, rd_en_i, done_i,
    output sample_ready_o, wr_en_o, wr_addr_o, wr_data_o,
           start_o, valid_to_read_o, rd_addr_o
  );

  modport slave (
    output sample_valid_i, sample_i, rd_en_i, done_i,
    input  sample_ready_o, wr_en_o, wr_addr_o, wr_data_o,
           start_o, valid_to_read_o, rd_addr_o
  );
endinterface

// File: rtl/mfcc_frame_scheduler.sv
// Circular sample-buffer pointer keeper and window-pass sequencer for the
// MFCC Hamming stage: launches one FRAME_LEN read pass every HOP_LEN samples.
module mfcc_frame_scheduler #(
  parameter int FRAME_LEN = 306,
  parameter int HOP_LEN   = 128,
  parameter int BUF_DEPTH = 512,
  parameter int ADDR_W    = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  flush_i,
  mfcc_frame_scheduler_if.master bus,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic [15:0]           frame_count_o
);
  localparam int FILL_W = ADDR_W + 1;
  localparam int OFF_W  = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] frame_base;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic [OFF_W-1:0]  offset;
  logic              accept;
  logic              done_evt;

  assign accept             = bus.sample_valid_i && (fill < FILL_W'(BUF_DEPTH));
  assign done_evt           = (state == WAIT_DONE) && bus.done_i;
  assign bus.sample_ready_o = (fill < FILL_W'(BUF_DEPTH));
  assign bus.rd_addr_o      = frame_base + ADDR_W'(offset);

  // A write landing in the done cycle nets +1 - HOP_LEN.
  always_comb begin
    fill_nxt = fill;
    if (accept)   fill_nxt = fill_nxt + FILL_W'(1);
    if (done_evt) fill_nxt = fill_nxt - FILL_W'(HOP_LEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      fill          <= '0;
      overrun_o     <= 1'b0;
      bus.wr_en_o   <= 1'b0;
      bus.wr_addr_o <= '0;
      bus.wr_data_o <= '0;
    end else if (flush_i) begin
      wr_ptr        <= '0;
      fill          <= '0;
      overrun_o     <= 1'b0;
      bus.wr_en_o   <= 1'b0;
      bus.wr_addr_o <= '0;
      bus.wr_data_o <= '0;
    end else begin
      bus.wr_en_o <= accept;
      if (accept) begin
        bus.wr_addr_o <= wr_ptr;
        bus.wr_data_o <= bus.sample_i;
        wr_ptr        <= wr_ptr + ADDR_W'(1);
      end
      if (bus.sample_valid_i && !accept) overrun_o <= 1'b1;
      fill <= fill_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      offset              <= '0;
      frame_base          <= '0;
      frame_count_o       <= '0;
      busy_o              <= 1'b0;
      bus.start_o         <= 1'b0;
      bus.valid_to_read_o <= 1'b0;
    end else if (flush_i) begin
      state               <= IDLE;
      offset              <= '0;
      frame_base          <= '0;
      frame_count_o       <= '0;
      busy_o              <= 1'b0;
      bus.start_o         <= 1'b0;
      bus.valid_to_read_o <= 1'b0;
    end else begin
      bus.start_o <= 1'b0;
      unique case (state)
        IDLE: if (enable_i && fill >= FILL_W'(FRAME_LEN)) begin
          state       <= START;
          bus.start_o <= 1'b1;
          busy_o      <= 1'b1;
        end
        START: begin
          offset              <= '0;
          state               <= STREAM;
          bus.valid_to_read_o <= 1'b1;
        end
        STREAM: if (bus.rd_en_i && bus.valid_to_read_o) begin
          offset <= offset + OFF_W'(1);
          if (offset == OFF_W'(FRAME_LEN - 1)) begin
            state               <= WAIT_DONE;
            bus.valid_to_read_o <= 1'b0;
          end
        end
        WAIT_DONE: if (bus.done_i) begin
          frame_base    <= frame_base + ADDR_W'(HOP_LEN);
          frame_count_o <= frame_count_o + 16'd1;
          state         <= IDLE;
          busy_o        <= 1'b0;
        end
      endcase
    end
  end
endmodule
